fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single write port of a `fifo` instance between `NUM_REQ` producers. It sits directly in front of the FIFO and drives its `wr`/`w_data` inputs. Each grant is held for a bounded burst of up to `BURST_MAX` words, then handed to the next requester in rotation. The arbiter stalls on FIFO `full` without losing a grant or a word.

---
 rtl/fifo_wr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin write arbiter sharing one FIFO write port between
//               NUM_REQ producers. Each grant accepts a burst of at most
//               BURST_MAX words, then control rotates to the next requester.
//               FIFO full stalls the current grant without revoking it.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          busy,
  input  logic                          full,
  output logic                          wr,
  output logic [DATA_WIDTH-1:0]         w_data
);

  // Index and burst counter widths
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_MAX - 1);

  // FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [IDX_W-1:0]      g;
  logic [IDX_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]      cnt;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IDX_W:0]        rot_sum  [NUM_REQ];
  logic [IDX_W-1:0]      rot_idx  [NUM_REQ];
  logic [NUM_REQ-1:0]    rot_req;
  logic [IDX_W-1:0]      pick;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic                  any_req;

  logic                  grant_active;
  logic                  accept;
  logic                  burst_done;
  logic                  withdraw;
  logic                  release_grant;
  logic [IDX_W-1:0]      g_inc;

  // Split the flat requester data bus into one word per requester
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Candidate k of the rotation is requester (rr_ptr + k) mod NUM_REQ.
  // rr_ptr and k are both below NUM_REQ, so a single conditional subtract
  // is enough to wrap.
  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rotate
      assign rot_sum[k] = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      assign rot_idx[k] = IDX_W'((rot_sum[k] >= NUM_REQ_EXT) ?
                                 (rot_sum[k] - NUM_REQ_EXT) : rot_sum[k]);
      assign rot_req[k] = req[rot_idx[k]];
    end
  endgenerate

  assign any_req = |req;

  // First active requester at or after rr_ptr; lowest rotation offset wins
  always_comb begin
    pick        = rot_idx[0];
    pick_onehot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        pick = rot_idx[k];
      end
    end
    pick_onehot[pick] = 1'b1;
  end

  // Grant-phase qualifiers, all from registered state plus live req/full
  assign grant_active  = (state == ST_GRANT);
  assign accept        = grant_active & req[g] & ~full;
  assign burst_done    = accept & (cnt == BURST_LAST);
  assign withdraw      = grant_active & ~req[g];
  assign release_grant = burst_done | withdraw;
  assign g_inc         = (g == LAST_IDX) ? '0 : g + 1'b1;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: arbitrate from IDLE, return after burst end or withdrawal
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_grant) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: write strobe, ack and data steered from the granted slot
  always_comb begin
    ack    = '0;
    ack[g] = accept;
    wr     = accept;
    w_data = data_arr[g];
  end

  // Grant index, rotation pointer, burst count and registered grant flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g      <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            g    <= pick;
            cnt  <= '0;
            gnt  <= pick_onehot;
            busy <= 1'b1;
          end
        end
        ST_GRANT: begin
          // Stall cycles (full) leave cnt untouched so they never shorten a burst
          if (accept) begin
            cnt <= cnt + 1'b1;
          end
          if (release_grant) begin
            rr_ptr <= g_inc;
            gnt    <= '0;
            busy   <= 1'b0;
          end
        end
        default: begin
          gnt  <= '0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed, table-driven bench for fifo_wr_arbiter with
//               NUM_REQ=4, DATA_WIDTH=8, BURST_MAX=4, plus hand-written
//               sequences for rotation, withdrawal, reset and FIFO fill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        busy;
  logic        full;
  logic        wr;
  logic [7:0]  w_data;

  int checks;
  int errors;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .BURST_MAX  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .gnt      (gnt),
    .busy     (busy),
    .full     (full),
    .wr       (wr),
    .w_data   (w_data)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  gnt;
    logic        busy;
    logic        wr;
    logic [7:0]  wd;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  // Withdrawal sequence: requester 1 granted while requester 3 waits
  logic [3:0] c_req [7] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010, 4'b1010};
  logic [3:0] c_ack [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
  logic [3:0] c_gnt [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000};

  int         order [5] = '{0, 1, 2, 3, 0};
  int         acks  [4];
  int         seqn  [4];
  logic [7:0] fifo_q [$];
  int         ack_id;
  int         ack1_cnt;
  logic [3:0] exp_ack;
  logic [7:0] exp_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Assert reset for about one cycle, check the reset outputs, release
  task automatic do_reset();
    reset    = 1'b0;
    req      = '0;
    full     = 1'b0;
    req_data = '0;
    @(negedge clk);
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack",  32'(ack),  32'h0);
    chk("rst_wr",   32'(wr),   32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req    = '0;
    full   = 1'b0;
    req_data = '0;

    //               req      full  data          ack      gnt      busy  wr    wd
    vt[0]  = '{4'b0001, 1'b0, 32'h0000_0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{4'b0001, 1'b0, 32'h0000_0010, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h10};
    vt[2]  = '{4'b0001, 1'b0, 32'h0000_0011, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11};
    vt[3]  = '{4'b0001, 1'b0, 32'h0000_0012, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h12};
    vt[4]  = '{4'b0001, 1'b0, 32'h0000_0013, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h13};
    vt[5]  = '{4'b0001, 1'b0, 32'h0000_0014, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{4'b0001, 1'b0, 32'h0000_0014, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h14};
    vt[7]  = '{4'b0001, 1'b0, 32'h0000_0015, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h15};
    vt[8]  = '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 8'h00};
    vt[9]  = '{4'b1001, 1'b0, 32'hA300_0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vt[10] = '{4'b1001, 1'b0, 32'hA300_0000, 4'b1000, 4'b1000, 1'b1, 1'b1, 8'hA3};
    vt[11] = '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b1000, 1'b1, 1'b0, 8'h00};
    vt[12] = '{4'b0101, 1'b0, 32'h00C2_00B0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vt[13] = '{4'b0101, 1'b0, 32'h00C2_00B0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'hB0};
    vt[14] = '{4'b0100, 1'b0, 32'h0020_0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 8'h00};
    vt[15] = '{4'b0100, 1'b0, 32'h0020_0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vt[16] = '{4'b0100, 1'b0, 32'h0020_0000, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'h20};
    vt[17] = '{4'b0100, 1'b0, 32'h0021_0000, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'h21};
    vt[18] = '{4'b0110, 1'b1, 32'h0022_0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 8'h00};
    vt[19] = '{4'b0110, 1'b1, 32'h0022_0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 8'h00};
    vt[20] = '{4'b0110, 1'b1, 32'h0022_0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 8'h00};
    vt[21] = '{4'b0100, 1'b0, 32'h0022_0000, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'h22};
    vt[22] = '{4'b0100, 1'b0, 32'h0023_0000, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'h23};
    vt[23] = '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};

    // ---------------- table: single requester, rotation, full stall --------
    do_reset();
    for (int i = 0; i < NV; i++) begin
      req      = vt[i].req;
      full     = vt[i].full;
      req_data = vt[i].data;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", i),  32'(ack),  32'(vt[i].ack));
      chk($sformatf("tbl%0d_gnt", i),  32'(gnt),  32'(vt[i].gnt));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("tbl%0d_wr", i),   32'(wr),   32'(vt[i].wr));
      if (vt[i].wr) begin
        chk($sformatf("tbl%0d_wdata", i), 32'(w_data), 32'(vt[i].wd));
      end
      @(posedge clk); #1;
    end

    // ---------------- all four requesters held for 25 cycles ---------------
    do_reset();
    for (int i = 0; i < 4; i++) acks[i] = 0;
    for (int c = 0; c < 25; c++) begin
      req      = 4'b1111;
      full     = 1'b0;
      req_data = 32'h3322_1100;
      @(negedge clk);
      exp_ack = (c % 5 == 0) ? 4'b0000 : 4'(1 << order[c / 5]);
      chk($sformatf("rr%0d_ack", c), 32'(ack), 32'(exp_ack));
      chk($sformatf("rr%0d_gnt", c), 32'(gnt), 32'(exp_ack));
      chk($sformatf("rr%0d_onehot", c), 32'($countones(ack) <= 1), 32'h1);
      if (exp_ack != 4'b0000) begin
        chk($sformatf("rr%0d_wdata", c), 32'(w_data), 32'(8'(8'h11 * order[c / 5])));
      end
      for (int i = 0; i < 4; i++) if (ack[i]) acks[i]++;
      @(posedge clk); #1;
    end
    chk("rr_acks0", 32'(acks[0]), 32'd8);
    chk("rr_acks1", 32'(acks[1]), 32'd4);
    chk("rr_acks2", 32'(acks[2]), 32'd4);
    chk("rr_acks3", 32'(acks[3]), 32'd4);

    // ---------------- requester 1 withdraws after two words ----------------
    do_reset();
    ack1_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      req      = c_req[c];
      full     = 1'b0;
      req_data = 32'h3322_1100;
      @(negedge clk);
      chk($sformatf("wd%0d_ack", c), 32'(ack), 32'(c_ack[c]));
      chk($sformatf("wd%0d_gnt", c), 32'(gnt), 32'(c_gnt[c]));
      if (ack[1]) ack1_cnt++;
      @(posedge clk); #1;
    end
    chk("wd_ack1_total", 32'(ack1_cnt), 32'd2);

    // ---------------- reset pulse in the middle of a burst -----------------
    do_reset();
    req_data = 32'h00C2_00B0;
    for (int c = 0; c < 5; c++) begin
      req = 4'b0001;
      @(negedge clk);
      @(posedge clk); #1;
    end
    req = 4'b0101;
    @(negedge clk);
    chk("mr_idle_gnt", 32'(gnt), 32'h0);
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mr_word%0d_ack", c), 32'(ack), 32'h4);
      chk($sformatf("mr_word%0d_wdata", c), 32'(w_data), 32'hC2);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    #2;
    reset = 1'b0;
    #1;
    chk("mr_async_ack",  32'(ack),  32'h0);
    chk("mr_async_wr",   32'(wr),   32'h0);
    chk("mr_async_gnt",  32'(gnt),  32'h0);
    chk("mr_async_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_post_idle", 32'(gnt), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_post_gnt",   32'(gnt),    32'h1);
    chk("mr_post_ack",   32'(ack),    32'h1);
    chk("mr_post_wdata", 32'(w_data), 32'hB0);
    @(posedge clk); #1;

    // ---------------- fill a 16-deep FIFO model ----------------------------
    do_reset();
    for (int i = 0; i < 4; i++) seqn[i] = 0;
    fifo_q.delete();
    for (int c = 0; c < 32; c++) begin
      full = (fifo_q.size() >= 16);
      req  = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {2'(i), 6'(seqn[i])};
      ack_id = -1;
      @(negedge clk);
      chk($sformatf("sb%0d_wr_full", c), 32'(wr & full), 32'h0);
      for (int i = 0; i < 4; i++) if (ack[i]) ack_id = i;
      chk($sformatf("sb%0d_wr_ack", c), 32'(wr), 32'(ack_id >= 0));
      if (wr && ack_id >= 0) begin
        exp_word = req_data[ack_id*8 +: 8];
        chk($sformatf("sb%0d_wdata", c), 32'(w_data), 32'(exp_word));
        fifo_q.push_back(w_data);
      end
      @(posedge clk); #1;
      if (ack_id >= 0) seqn[ack_id]++;
    end
    chk("sb_fill_level", 32'(fifo_q.size()), 32'd16);
    for (int k = 0; k < 16 && k < fifo_q.size(); k++) begin
      exp_word = {2'(k / 4), 6'(k % 4)};
      chk($sformatf("sb_entry%0d", k), 32'(fifo_q[k]), 32'(exp_word));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
